operand_fetch_stage: RTL and testbench

- Decode-to-execute stage directly downstream of the register file.
- Drives the register file read addresses and consumes its two read ports.
- Resolves RAW hazards by bypassing from the EX, MEM and WB stages, and stalls on load-use hazards.
- Latches resolved operands and control into the ID/EX pipeline register.
- Keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/operand_fetch_stage.sv | 120 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// ID/EX operand fetch: register-file read, EX/MEM/WB bypass, load-use stall
// detection, the ID/EX pipeline register and a saturating stall-cycle counter.
module operand_fetch_stage #(
    parameter int CTRL_W  = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_dst,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic [31:0]        id_imm,
    input  logic [CTRL_W-1:0]  id_ctrl,
    output logic [4:0]         rf_readreg1,
    output logic [4:0]         rf_readreg2,
    input  logic [31:0]        rf_readdata1,
    input  logic [31:0]        rf_readdata2,
    input  logic [31:0]        ex_alu_result,
    input  logic               exmem_regwrite,
    input  logic               exmem_memread,
    input  logic [4:0]         exmem_writereg,
    input  logic [31:0]        exmem_result,
    input  logic               memwb_regwrite,
    input  logic [4:0]         memwb_writereg,
    input  logic [31:0]        memwb_writedata,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_dst,
    output logic [31:0]        ex_op1,
    output logic [31:0]        ex_op2,
    output logic [31:0]        ex_imm,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [COUNT_W-1:0] stall_cycles
);

    logic [31:0] op1;
    logic [31:0] op2;
    logic        hz_rs;
    logic        hz_rt;

    assign rf_readreg1 = id_rs;
    assign rf_readreg2 = id_rt;

    function automatic logic [31:0] bypass(input logic [4:0] src, input logic [31:0] rf);
        logic [31:0] val;
        val = rf;
        if (src == 5'd0)
            val = '0;
        else if (ex_valid && ex_regwrite && ex_dst == src)
            val = ex_alu_result;
        else if (exmem_regwrite && exmem_writereg == src)
            val = exmem_result;
        else if (memwb_regwrite && memwb_writereg == src)
            val = memwb_writedata;
        return val;
    endfunction

    // An ALU result in EX shadows an older load to the same register in MEM.
    function automatic logic load_hazard(input logic [4:0] src, input logic used);
        logic ex_load;
        logic ex_hit;
        logic mem_load;
        ex_load  = ex_valid && ex_memread && ex_dst == src;
        ex_hit   = ex_valid && ex_regwrite && ex_dst == src;
        mem_load = exmem_memread && exmem_regwrite && exmem_writereg == src;
        return used && (src != 5'd0) && (ex_load || (!ex_hit && mem_load));
    endfunction

    always_comb begin
        op1   = bypass(id_rs, rf_readdata1);
        op2   = bypass(id_rt, rf_readdata2);
        hz_rs = load_hazard(id_rs, id_uses_rs);
        hz_rt = load_hazard(id_rt, id_uses_rt);
        stall = !rst && id_valid && !flush && (hz_rs || hz_rt);
    end

    always_ff @(posedge clk) begin
        if (rst || flush || stall || !id_valid) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_dst      <= '0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_dst      <= id_dst;
            ex_op1      <= op1;
            ex_op2      <= op2;
            ex_imm      <= id_imm;
            ex_ctrl     <= id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed vector table, load-use
// and saturation sequences, and random traffic against a producer-list model.
module tb_operand_fetch_stage;

    localparam int CTRL_W  = 8;
    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               id_valid;
    logic [4:0]         id_rs, id_rt, id_dst;
    logic               id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic [31:0]        id_imm;
    logic [CTRL_W-1:0]  id_ctrl;
    logic [4:0]         rf_readreg1, rf_readreg2;
    logic [31:0]        rf_readdata1, rf_readdata2;
    logic [31:0]        ex_alu_result;
    logic               exmem_regwrite, exmem_memread;
    logic [4:0]         exmem_writereg;
    logic [31:0]        exmem_result;
    logic               memwb_regwrite;
    logic [4:0]         memwb_writereg;
    logic [31:0]        memwb_writedata;
    logic               flush;
    logic               stall;
    logic               ex_valid, ex_regwrite, ex_memread;
    logic [4:0]         ex_rs, ex_rt, ex_dst;
    logic [31:0]        ex_op1, ex_op2, ex_imm;
    logic [CTRL_W-1:0]  ex_ctrl;
    logic [COUNT_W-1:0] stall_cycles;

    operand_fetch_stage #(.CTRL_W(CTRL_W), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_readreg1(rf_readreg1), .rf_readreg2(rf_readreg2),
        .rf_readdata1(rf_readdata1), .rf_readdata2(rf_readdata2),
        .ex_alu_result(ex_alu_result),
        .exmem_regwrite(exmem_regwrite), .exmem_memread(exmem_memread),
        .exmem_writereg(exmem_writereg), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_writereg(memwb_writereg),
        .memwb_writedata(memwb_writedata),
        .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_regwrite = 0; id_memread = 0;
        id_imm = 0; id_ctrl = 0; rf_readdata1 = 0; rf_readdata2 = 0;
        ex_alu_result = 0; exmem_regwrite = 0; exmem_memread = 0;
        exmem_writereg = 0; exmem_result = 0; memwb_regwrite = 0;
        memwb_writereg = 0; memwb_writedata = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Directed vectors: "p*" is the instruction latched into EX first.
    typedef struct {
        logic        pv;  logic [4:0] pd;  logic prw; logic pmr;
        logic [4:0]  rs;  logic [4:0] rt;  logic urs; logic urt; logic fl;
        logic [31:0] alu;
        logic        mwe; logic mrd; logic [4:0] mreg; logic [31:0] mres;
        logic        wwe; logic [4:0] wreg; logic [31:0] wdat;
        logic [31:0] rf1; logic [31:0] rf2;
        logic        e_stall; logic e_valid; logic [31:0] e_op1; logic [31:0] e_op2;
    } vec_t;

    vec_t vecs[11];

    // Reference model: EX state plus priority-ordered producer list.
    typedef struct {
        logic        act;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        load;
    } prod_t;

    logic              m_valid, m_rw, m_mr;
    logic [4:0]        m_rs, m_rt, m_dst;
    logic [31:0]       m_op1, m_op2, m_imm;
    logic [CTRL_W-1:0] m_ctrl;
    int unsigned       m_cnt;

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_mr = 0; m_rs = 0; m_rt = 0; m_dst = 0;
        m_op1 = 0; m_op2 = 0; m_imm = 0; m_ctrl = 0;
    endtask

    function automatic void resolve(input logic [4:0] src, input logic [31:0] rf,
                                    output logic [31:0] val, output logic ld);
        prod_t p[3];
        logic  found;
        p[0] = '{m_valid && m_rw, m_dst, ex_alu_result, m_mr};
        p[1] = '{exmem_regwrite, exmem_writereg, exmem_result, exmem_memread};
        p[2] = '{memwb_regwrite, memwb_writereg, memwb_writedata, 1'b0};
        val = rf;
        ld = 0;
        found = 0;
        if (src == 0) val = 0;
        else
            for (int i = 0; i < 3; i++)
                if (!found && p[i].act && p[i].dst == src) begin
                    found = 1;
                    val = p[i].data;
                    ld = p[i].load;
                end
    endfunction

    initial begin
        logic [31:0] v1, v2;
        logic        l1, l2, exp_stall, hold;

        vecs[0]  = '{1,5,1,0, 5,0,1,0,0, 'h44, 1,0,5,'h22, 1,5,'h33, 'h11,'h99, 0,1,'h44,0};
        vecs[1]  = '{0,5,1,0, 5,0,1,0,0, 'h44, 1,0,5,'h22, 1,5,'h33, 'h11,0, 0,1,'h22,0};
        vecs[2]  = '{0,5,1,0, 5,0,1,0,0, 'h44, 0,0,5,'h22, 1,5,'h33, 'h11,0, 0,1,'h33,0};
        vecs[3]  = '{0,0,0,0, 5,6,1,1,0, 'h44, 0,0,0,0, 0,0,0, 'h11,'h66, 0,1,'h11,'h66};
        vecs[4]  = '{1,0,1,1, 0,0,1,1,0, 'hDEAD, 1,1,0,'hDEAD, 1,0,'hDEAD, 'hDEAD,'hDEAD, 0,1,0,0};
        vecs[5]  = '{1,3,1,0, 1,3,1,1,0, 'h55, 0,0,0,0, 0,0,0, 'h10,'h20, 0,1,'h10,'h55};
        vecs[6]  = '{1,7,1,1, 0,7,0,1,1, 'h77, 0,0,0,0, 0,0,0, 0,'h20, 0,0,0,0};
        vecs[7]  = '{0,0,0,0, 4,0,1,0,0, 0, 1,1,4,'h40, 0,0,0, 'h11,0, 1,0,0,0};
        vecs[8]  = '{1,4,1,0, 4,0,1,0,0, 'h88, 1,1,4,'h40, 0,0,0, 'h11,0, 0,1,'h88,0};
        vecs[9]  = '{1,7,1,1, 0,7,0,0,0, 'h77, 0,0,0,0, 0,0,0, 0,'h20, 0,1,0,'h77};
        vecs[10] = '{0,0,0,0, 0,2,0,1,0, 0, 0,0,0,0, 1,2,'hAB, 0,'h20, 0,1,0,'hAB};

        // Reset with random inputs.
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            id_valid = 1'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
            id_dst = 5'($urandom); id_uses_rs = 1; id_uses_rt = 1;
            id_regwrite = 1'($urandom); id_memread = 1'($urandom);
            id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
            rf_readdata1 = $urandom; rf_readdata2 = $urandom; ex_alu_result = $urandom;
            exmem_regwrite = 1; exmem_memread = 1; exmem_writereg = id_rs;
            exmem_result = $urandom; memwb_regwrite = 1'($urandom);
            memwb_writereg = 5'($urandom); memwb_writedata = $urandom; flush = 1'($urandom);
            tick();
        end
        chk("rst_valid", {31'b0, ex_valid}, 0);
        chk("rst_op1", ex_op1, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_ctrl", {24'b0, ex_ctrl}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_count", {16'b0, stall_cycles}, 0);
        rst = 0;
        idle();
        tick();

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            idle();
            id_valid = vecs[i].pv; id_dst = vecs[i].pd;
            id_regwrite = vecs[i].prw; id_memread = vecs[i].pmr;
            tick();
            idle();
            id_valid = 1; id_dst = 9; id_imm = 'h1000 + i;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt; flush = vecs[i].fl;
            ex_alu_result = vecs[i].alu;
            exmem_regwrite = vecs[i].mwe; exmem_memread = vecs[i].mrd;
            exmem_writereg = vecs[i].mreg; exmem_result = vecs[i].mres;
            memwb_regwrite = vecs[i].wwe; memwb_writereg = vecs[i].wreg;
            memwb_writedata = vecs[i].wdat;
            rf_readdata1 = vecs[i].rf1; rf_readdata2 = vecs[i].rf2;
            #1;
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
            tick();
            chk($sformatf("vec%0d_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("vec%0d_op1", i), ex_op1, vecs[i].e_op1);
            chk($sformatf("vec%0d_op2", i), ex_op2, vecs[i].e_op2);
        end
        chk("table_count", {16'b0, stall_cycles}, 1);

        // Load in EX followed by a dependent instruction: two stalls.
        idle();
        do_reset();
        id_valid = 1; id_dst = 7; id_regwrite = 1; id_memread = 1;
        tick();
        chk("lu_load_in_ex", {31'b0, ex_memread}, 1);
        idle();
        id_valid = 1; id_rt = 7; id_uses_rt = 1; id_dst = 8; id_regwrite = 1;
        rf_readdata2 = 'h0BAD;
        #1 chk("lu_stall1", {31'b0, stall}, 1);
        tick();
        chk("lu_bubble1", {31'b0, ex_valid}, 0);
        exmem_memread = 1; exmem_regwrite = 1; exmem_writereg = 7; exmem_result = 'h1234;
        #1 chk("lu_stall2", {31'b0, stall}, 1);
        tick();
        chk("lu_bubble2", {31'b0, ex_valid}, 0);
        exmem_memread = 0; exmem_regwrite = 0; exmem_writereg = 0;
        memwb_regwrite = 1; memwb_writereg = 7; memwb_writedata = 'hCAFE;
        #1 chk("lu_stall3", {31'b0, stall}, 0);
        tick();
        chk("lu_valid", {31'b0, ex_valid}, 1);
        chk("lu_op2", ex_op2, 'hCAFE);
        chk("lu_count", {16'b0, stall_cycles}, 2);

        // Random traffic against the model.
        idle();
        do_reset();
        model_clear();
        m_cnt = 0;
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                id_valid = ($urandom_range(0, 7) != 0);
                id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
                id_dst = 5'($urandom_range(0, 3));
                id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
                id_memread = ($urandom_range(0, 2) == 0);
                id_regwrite = id_memread | 1'($urandom);
                id_imm = $urandom; id_ctrl = CTRL_W'($urandom);
            end
            rf_readdata1 = $urandom; rf_readdata2 = $urandom; ex_alu_result = $urandom;
            exmem_memread = ($urandom_range(0, 3) == 0);
            exmem_regwrite = exmem_memread | 1'($urandom);
            exmem_writereg = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_regwrite = 1'($urandom); memwb_writereg = 5'($urandom_range(0, 3));
            memwb_writedata = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            #1;
            resolve(id_rs, rf_readdata1, v1, l1);
            resolve(id_rt, rf_readdata2, v2, l2);
            exp_stall = !rst && id_valid && !flush && ((id_uses_rs && l1) || (id_uses_rt && l2));
            chk("rnd_stall", {31'b0, stall}, {31'b0, exp_stall});
            if (rst) begin
                model_clear();
                m_cnt = 0;
            end else begin
                if (exp_stall && m_cnt < (1 << COUNT_W) - 1) m_cnt++;
                if (flush || exp_stall || !id_valid) model_clear();
                else begin
                    m_valid = 1; m_rw = id_regwrite; m_mr = id_memread;
                    m_rs = id_rs; m_rt = id_rt; m_dst = id_dst;
                    m_op1 = v1; m_op2 = v2; m_imm = id_imm; m_ctrl = id_ctrl;
                end
            end
            hold = exp_stall;
            tick();
            chk("rnd_valid", {31'b0, ex_valid}, {31'b0, m_valid});
            chk("rnd_ctl", {29'b0, ex_regwrite, ex_memread, 1'b0}, {29'b0, m_rw, m_mr, 1'b0});
            chk("rnd_regs", {17'b0, ex_rs, ex_rt, ex_dst}, {17'b0, m_rs, m_rt, m_dst});
            chk("rnd_op1", ex_op1, m_op1);
            chk("rnd_op2", ex_op2, m_op2);
            chk("rnd_imm", ex_imm, m_imm);
            chk("rnd_ctrl", {24'b0, ex_ctrl}, {24'b0, m_ctrl});
            chk("rnd_count", {16'b0, stall_cycles}, m_cnt);
        end
        rst = 0;

        // Continuous stall past counter wrap, then reset.
        idle();
        do_reset();
        id_valid = 1; id_rs = 4; id_uses_rs = 1;
        exmem_memread = 1; exmem_regwrite = 1; exmem_writereg = 4;
        for (int n = 0; n < (1 << COUNT_W) + 3; n++) @(posedge clk);
        #1;
        chk("sat_stall", {31'b0, stall}, 1);
        chk("sat_count", {16'b0, stall_cycles}, 'hFFFF);
        do_reset();
        chk("sat_rst_count", {16'b0, stall_cycles}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
